parking_gate_ctrl: RTL and testbench
====================================

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd1000: cycles a gate stays open waiting for the car to pass before aborting.
REQ-002 Parameter HOLD_CYCLES, default 8'd4: cycles the gate stays open after the pass sensor clears.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 start  in  1  synchronous active-low reset; low = reset, high = run.
REQ-006 entry_req  in  1  level, car present at entry loop.
REQ-007 entry_is_uni  in  1  badge at entry: 1 = university car.
REQ-008 entry_pass  in  1  level, entry barrier beam broken.
REQ-009 exit_req / exit_is_uni / exit_pass  in  1 each  exit-lane equivalents.
REQ-010 uni_is_vacated_space / is_vacated_space  in  1 each  vacancy flags from the parking counter.
REQ-011 car_entered / is_uni_car_entered  out  1 each  one-cycle entry event pulse and its class (class valid only while pulse high, else 0).
REQ-012 car_exited / is_uni_car_exited  out  1 each  one-cycle exit event pulse and its class (same rule).
REQ-013 entry_gate_open / exit_gate_open  out  1 each  barrier drive.
REQ-014 entry_denied  out  1  one-cycle pulse, entry refused for lack of space.
REQ-015 gate_timeout  out  1  one-cycle pulse, either lane aborted on timeout.

Function
REQ-016 Each lane SHALL run an independent FSM: IDLE, OPEN, PASSING, HOLD, WAIT_CLEAR.
REQ-017 Entry IDLE: on rising edge of entry_req, latch entry_is_uni; if the matching vacancy flag is 1, go OPEN next cycle; else pulse entry_denied and go WAIT_CLEAR.
REQ-018 Exit IDLE: on rising edge of exit_req, latch exit_is_uni and go OPEN unconditionally.
REQ-019 OPEN: gate_open = 1; on *_pass = 1 go PASSING.
REQ-020 PASSING: gate_open = 1; on *_pass falling to 0, queue one event for the lane (latched class) and go HOLD.
REQ-021 HOLD: gate_open = 1 for exactly HOLD_CYCLES cycles, then go WAIT_CLEAR with gate_open = 0.
REQ-022 WAIT_CLEAR: return to IDLE once *_req = 0; a request held high never re-triggers.
REQ-023 Event output SHALL appear the cycle after the pass falling edge is sampled (latency 1) unless delayed by REQ-024.
REQ-024 Simultaneous queued entry and exit events: entry pulses first; exit pulses the next cycle; car_entered and car_exited are never high in the same cycle.
REQ-025 Each queued event SHALL produce exactly one pulse; none is dropped or duplicated.
REQ-026 Vacancy flags SHALL be sampled only in IDLE; later changes do not close an open gate.
REQ-027 Counters: 16-bit timeout counter and 8-bit hold counter per lane, cleared on every state entry, saturating, never wrapping.

Reset
REQ-028 While start = 0 at a clock edge: both FSMs go IDLE; all outputs 0; counters, latched classes and pending events cleared.
REQ-029 Reset mid-operation SHALL close both gates the next cycle and discard pending events with no pulse.
REQ-030 Edge detectors SHALL reset their previous-value registers to 0, so a request already high when start rises counts as a new rising edge.

Configuration
REQ-031 Macro GATE_TIMEOUT_EN: defined -> in OPEN, after TIMEOUT_CYCLES cycles without *_pass, pulse gate_timeout, close the gate, queue no event, go WAIT_CLEAR.
REQ-032 GATE_TIMEOUT_EN undefined -> OPEN waits indefinitely, gate_timeout is tied 0, no timeout counters are built.

Verification
REQ-033 Uni entry: vacancy flags 1, entry_req up, entry_is_uni = 1, pass high 3 cycles then low -> gate opens 1 cycle after request; car_entered = 1 and is_uni_car_entered = 1 for one cycle; gate closes after 4 hold cycles.
REQ-034 Full lot: uni_is_vacated_space = 0, uni entry request -> entry_denied pulse once, gate never opens, no car_entered.
REQ-035 Collision: entry and exit pass fall in the same cycle -> car_entered at cycle N, car_exited at N+1, never overlapping.
REQ-036 Timeout (GATE_TIMEOUT_EN, TIMEOUT_CYCLES = 10): request with no pass -> gate_timeout at cycle 10 of OPEN, gate closes, no event; without the macro, gate stays open for 50 cycles.
REQ-037 Reset during PASSING: start = 0 for 1 cycle -> gates 0 the next cycle, no event pulse, IDLE after start returns high.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// Parking barrier controller: independent entry and exit lane FSMs with
// vacancy gating, pass detection, hold-open timing and event pulse output.
//
// Build option: define GATE_TIMEOUT_EN to abort an OPEN lane after
// TIMEOUT_CYCLES cycles without a pass; undefined, OPEN waits forever and
// gate_timeout is tied low with no timeout counters built.
//
// parking_gate_lane ports:
//   clk, start          clock, synchronous active-low reset
//   req, is_uni, pass   lane request loop, badge class, barrier beam
//   uni_vac, vac        vacancy flags (ignored when CHECK_SPACE = 0)
//   gate_open           barrier drive
//   evt, evt_uni        car-passed strobe (combinational) and its class
//   denied, timeout     refusal / abort strobes (combinational)
//
// parking_gate_ctrl ports:
//   clk, start                               clock, sync active-low reset
//   entry_req/entry_is_uni/entry_pass        entry lane inputs
//   exit_req/exit_is_uni/exit_pass           exit lane inputs
//   uni_is_vacated_space/is_vacated_space    vacancy flags
//   car_entered/is_uni_car_entered           entry event pulse + class
//   car_exited/is_uni_car_exited             exit event pulse + class
//   entry_gate_open/exit_gate_open           barrier drives
//   entry_denied                             refusal pulse
//   gate_timeout                             abort pulse, either lane

module parking_gate_lane #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
    parameter logic [7:0]  HOLD_CYCLES    = 8'd4,
    parameter bit          CHECK_SPACE    = 1'b1
) (
    input  logic clk,
    input  logic start,
    input  logic req,
    input  logic is_uni,
    input  logic pass,
    input  logic uni_vac,
    input  logic vac,
    output logic gate_open,
    output logic evt,
    output logic evt_uni,
    output logic denied,
    output logic timeout
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_OPEN       = 3'd1;
    localparam logic [2:0] S_PASSING    = 3'd2;
    localparam logic [2:0] S_HOLD       = 3'd3;
    localparam logic [2:0] S_WAIT_CLEAR = 3'd4;

    logic [2:0] state;
    logic [2:0] state_d;
    logic       req_q;
    logic       req_rise;
    logic       cls;
    logic       space_ok;
    logic [7:0] hold_cnt;
    logic       hold_done;
    logic       to_hit;

    // req_q resets to 0 so a request already high at reset release
    // is seen as a fresh rising edge.
    assign req_rise  = req & ~req_q;
    assign space_ok  = is_uni ? uni_vac : vac;
    assign hold_done = ({1'b0, hold_cnt} + 9'd1) >= {1'b0, HOLD_CYCLES};
    assign gate_open = (state == S_OPEN) || (state == S_PASSING) ||
                       (state == S_HOLD);
    assign evt_uni   = cls;

`ifdef GATE_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign to_hit = ({1'b0, to_cnt} + 17'd1) >= {1'b0, TIMEOUT_CYCLES};

    // Cleared on every state change, saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (!start) begin
            to_cnt <= 16'd0;
        end else if (state_d != state) begin
            to_cnt <= 16'd0;
        end else if (to_cnt != 16'hFFFF) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d = state;
        evt     = 1'b0;
        denied  = 1'b0;
        timeout = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_rise) begin
                    if (!CHECK_SPACE || space_ok) begin
                        state_d = S_OPEN;
                    end else begin
                        denied  = 1'b1;
                        state_d = S_WAIT_CLEAR;
                    end
                end
            end
            S_OPEN: begin
                if (pass) begin
                    state_d = S_PASSING;
                end else if (to_hit) begin
                    timeout = 1'b1;
                    state_d = S_WAIT_CLEAR;
                end
            end
            S_PASSING: begin
                // Entered with pass high, so a low sample is the fall.
                if (!pass) begin
                    evt     = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_done) begin
                    state_d = S_WAIT_CLEAR;
                end
            end
            S_WAIT_CLEAR: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!start) begin
            state <= S_IDLE;
            req_q <= 1'b0;
            cls   <= 1'b0;
        end else begin
            state <= state_d;
            req_q <= req;
            if ((state == S_IDLE) && req_rise) begin
                cls <= is_uni;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!start) begin
            hold_cnt <= 8'd0;
        end else if (state_d != state) begin
            hold_cnt <= 8'd0;
        end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

endmodule

module parking_gate_ctrl #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
    parameter logic [7:0]  HOLD_CYCLES    = 8'd4
) (
    input  logic clk,
    input  logic start,
    input  logic entry_req,
    input  logic entry_is_uni,
    input  logic entry_pass,
    input  logic exit_req,
    input  logic exit_is_uni,
    input  logic exit_pass,
    input  logic uni_is_vacated_space,
    input  logic is_vacated_space,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic car_exited,
    output logic is_uni_car_exited,
    output logic entry_gate_open,
    output logic exit_gate_open,
    output logic entry_denied,
    output logic gate_timeout
);

    logic ent_evt;
    logic ent_uni;
    logic ent_denied;
    logic ent_to;
    logic ex_evt;
    logic ex_uni;
    logic ex_denied_nc;
    logic ex_to;
    logic ex_pend;
    logic ex_pend_uni;
    logic ex_avail;
    logic ex_avail_uni;
    logic ex_fire;

    parking_gate_lane #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .CHECK_SPACE    (1'b1)
    ) u_entry (
        .clk       (clk),
        .start     (start),
        .req       (entry_req),
        .is_uni    (entry_is_uni),
        .pass      (entry_pass),
        .uni_vac   (uni_is_vacated_space),
        .vac       (is_vacated_space),
        .gate_open (entry_gate_open),
        .evt       (ent_evt),
        .evt_uni   (ent_uni),
        .denied    (ent_denied),
        .timeout   (ent_to)
    );

    parking_gate_lane #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .CHECK_SPACE    (1'b0)
    ) u_exit (
        .clk       (clk),
        .start     (start),
        .req       (exit_req),
        .is_uni    (exit_is_uni),
        .pass      (exit_pass),
        .uni_vac   (1'b1),
        .vac       (1'b1),
        .gate_open (exit_gate_open),
        .evt       (ex_evt),
        .evt_uni   (ex_uni),
        .denied    (ex_denied_nc),
        .timeout   (ex_to)
    );

    // Entry always wins the shared event slot; an exit that collides
    // with an entry is parked in ex_pend and issued the next cycle.
    assign ex_avail     = ex_pend | ex_evt;
    assign ex_avail_uni = ex_pend ? ex_pend_uni : ex_uni;
    assign ex_fire      = ex_avail & ~ent_evt;

    always_ff @(posedge clk) begin
        if (!start) begin
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            car_exited         <= 1'b0;
            is_uni_car_exited  <= 1'b0;
            entry_denied       <= 1'b0;
            gate_timeout       <= 1'b0;
            ex_pend            <= 1'b0;
            ex_pend_uni        <= 1'b0;
        end else begin
            car_entered        <= ent_evt;
            is_uni_car_entered <= ent_evt & ent_uni;
            car_exited         <= ex_fire;
            is_uni_car_exited  <= ex_fire & ex_avail_uni;
            entry_denied       <= ent_denied & ~ex_denied_nc | ent_denied;
            gate_timeout       <= ent_to | ex_to;
            if (ex_fire) begin
                // A fresh exit arriving as the parked one issues stays parked.
                ex_pend     <= ex_pend & ex_evt;
                ex_pend_uni <= ex_uni;
            end else if (ex_evt) begin
                ex_pend     <= 1'b1;
                ex_pend_uni <= ex_uni;
            end
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: scoreboard of expected
// entry/exit events plus direct checks of gate, denial and timeout outputs.

module tb_parking_gate_ctrl;

    logic clk;
    logic start;
    logic entry_req;
    logic entry_is_uni;
    logic entry_pass;
    logic exit_req;
    logic exit_is_uni;
    logic exit_pass;
    logic uni_is_vacated_space;
    logic is_vacated_space;
    logic car_entered;
    logic is_uni_car_entered;
    logic car_exited;
    logic is_uni_car_exited;
    logic entry_gate_open;
    logic exit_gate_open;
    logic entry_denied;
    logic gate_timeout;

    typedef struct packed {
        logic ex;
        logic uni;
        int   due;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_chk;
    int   n_pass;

    parking_gate_ctrl #(
        .TIMEOUT_CYCLES (16'd10),
        .HOLD_CYCLES    (8'd4)
    ) dut (
        .clk                  (clk),
        .start                (start),
        .entry_req            (entry_req),
        .entry_is_uni         (entry_is_uni),
        .entry_pass           (entry_pass),
        .exit_req             (exit_req),
        .exit_is_uni          (exit_is_uni),
        .exit_pass            (exit_pass),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited),
        .entry_gate_open      (entry_gate_open),
        .exit_gate_open       (exit_gate_open),
        .entry_denied         (entry_denied),
        .gate_timeout         (gate_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic ex, input logic uni, input int due);
        exp_t e;
        e.ex  = ex;
        e.uni = uni;
        e.due = due;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic ex, input logic uni);
        exp_t e;
        if (sb.size() == 0) begin
            check(ex ? "spurious_exit" : "spurious_entry", 1, 0);
        end else begin
            e = sb.pop_front();
            check("evt_kind", {31'd0, ex}, {31'd0, e.ex});
            check("evt_class", {31'd0, uni}, {31'd0, e.uni});
            check("evt_cycle", cyc, e.due);
        end
    endtask

    always @(negedge clk) begin
        if (start) begin
            check("overlap", {31'd0, car_entered & car_exited}, 0);
            check("ent_cls_idle",
                  {31'd0, is_uni_car_entered & ~car_entered}, 0);
            check("ex_cls_idle",
                  {31'd0, is_uni_car_exited & ~car_exited}, 0);
`ifndef GATE_TIMEOUT_EN
            check("no_timeout", {31'd0, gate_timeout}, 0);
`endif
            if (car_entered) pop_cmp(1'b0, is_uni_car_entered);
            if (car_exited)  pop_cmp(1'b1, is_uni_car_exited);
        end
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        start = 1'b0;
        entry_req = 1'b0;
        entry_is_uni = 1'b0;
        entry_pass = 1'b0;
        exit_req = 1'b0;
        exit_is_uni = 1'b0;
        exit_pass = 1'b0;
        uni_is_vacated_space = 1'b0;
        is_vacated_space = 1'b0;
        tick(2);
        check("rst_egate", {31'd0, entry_gate_open}, 0);
        check("rst_xgate", {31'd0, exit_gate_open}, 0);
        check("rst_ent", {31'd0, car_entered}, 0);
        check("rst_exit", {31'd0, car_exited}, 0);
        check("rst_denied", {31'd0, entry_denied}, 0);
        check("rst_timeout", {31'd0, gate_timeout}, 0);

        // Uni entry, pass high 3 cycles, 4-cycle hold.
        uni_is_vacated_space = 1'b1;
        is_vacated_space = 1'b1;
        start = 1'b1;
        tick(1);
        entry_req = 1'b1;
        entry_is_uni = 1'b1;
        check("s1_closed_pre", {31'd0, entry_gate_open}, 0);
        tick(1);
        check("s1_open", {31'd0, entry_gate_open}, 1);
        entry_is_uni = 1'b0;
        entry_pass = 1'b1;
        tick(3);
        check("s1_passing", {31'd0, entry_gate_open}, 1);
        entry_pass = 1'b0;
        push(1'b0, 1'b1, cyc + 1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("s1_hold", {31'd0, entry_gate_open}, 1);
        end
        tick(1);
        check("s1_close", {31'd0, entry_gate_open}, 0);
        tick(3);
        check("s1_no_retrig", {31'd0, entry_gate_open}, 0);
        entry_req = 1'b0;
        tick(2);

        // Full lot for uni cars.
        uni_is_vacated_space = 1'b0;
        entry_req = 1'b1;
        entry_is_uni = 1'b1;
        tick(1);
        check("s2_denied", {31'd0, entry_denied}, 1);
        check("s2_gate", {31'd0, entry_gate_open}, 0);
        tick(1);
        check("s2_denied_once", {31'd0, entry_denied}, 0);
        tick(3);
        check("s2_gate_late", {31'd0, entry_gate_open}, 0);
        check("s2_denied_late", {31'd0, entry_denied}, 0);
        entry_req = 1'b0;
        tick(2);

        // Collision: non-uni entry (general space free) + uni exit.
        is_vacated_space = 1'b1;
        entry_req = 1'b1;
        entry_is_uni = 1'b0;
        exit_req = 1'b1;
        exit_is_uni = 1'b1;
        tick(1);
        check("s3_egate", {31'd0, entry_gate_open}, 1);
        check("s3_xgate", {31'd0, exit_gate_open}, 1);
        entry_pass = 1'b1;
        exit_pass = 1'b1;
        tick(2);
        entry_pass = 1'b0;
        exit_pass = 1'b0;
        push(1'b0, 1'b0, cyc + 1);
        push(1'b1, 1'b1, cyc + 2);
        tick(6);
        check("s3_egate_closed", {31'd0, entry_gate_open}, 0);
        check("s3_xgate_closed", {31'd0, exit_gate_open}, 0);
        entry_req = 1'b0;
        exit_req = 1'b0;
        tick(2);

        // Open both, then drop vacancy; OPEN without pass.
        uni_is_vacated_space = 1'b1;
        entry_req = 1'b1;
        entry_is_uni = 1'b1;
        exit_req = 1'b1;
        exit_is_uni = 1'b0;
        tick(1);
        check("s4_egate", {31'd0, entry_gate_open}, 1);
        check("s4_xgate", {31'd0, exit_gate_open}, 1);
        uni_is_vacated_space = 1'b0;
        is_vacated_space = 1'b0;
`ifdef GATE_TIMEOUT_EN
        tick(9);
        check("s4_egate_c10", {31'd0, entry_gate_open}, 1);
        check("s4_to_early", {31'd0, gate_timeout}, 0);
        tick(1);
        check("s4_timeout", {31'd0, gate_timeout}, 1);
        check("s4_egate_to", {31'd0, entry_gate_open}, 0);
        check("s4_xgate_to", {31'd0, exit_gate_open}, 0);
        tick(1);
        check("s4_timeout_once", {31'd0, gate_timeout}, 0);
`else
        tick(50);
        check("s4_egate_50", {31'd0, entry_gate_open}, 1);
        check("s4_xgate_50", {31'd0, exit_gate_open}, 1);
        entry_pass = 1'b1;
        tick(1);
        entry_pass = 1'b0;
        push(1'b0, 1'b1, cyc + 1);
        tick(1);
        exit_pass = 1'b1;
        tick(1);
        exit_pass = 1'b0;
        push(1'b1, 1'b0, cyc + 1);
        tick(6);
        check("s4_egate_closed", {31'd0, entry_gate_open}, 0);
        check("s4_xgate_closed", {31'd0, exit_gate_open}, 0);
`endif
        entry_req = 1'b0;
        exit_req = 1'b0;
        uni_is_vacated_space = 1'b1;
        is_vacated_space = 1'b1;
        tick(2);

        // Reset while PASSING: gate drops, no event.
        entry_req = 1'b1;
        entry_is_uni = 1'b1;
        tick(1);
        entry_pass = 1'b1;
        tick(1);
        check("s5_passing", {31'd0, entry_gate_open}, 1);
        start = 1'b0;
        entry_pass = 1'b0;
        entry_req = 1'b0;
        tick(1);
        check("s5_gate_rst", {31'd0, entry_gate_open}, 0);
        check("s5_no_evt", {31'd0, car_entered}, 0);
        start = 1'b1;
        tick(2);
        check("s5_idle", {31'd0, entry_gate_open}, 0);

        // Request high across reset release is a new rising edge.
        start = 1'b0;
        entry_req = 1'b1;
        entry_is_uni = 1'b0;
        tick(2);
        check("s6_held_rst", {31'd0, entry_gate_open}, 0);
        start = 1'b1;
        tick(1);
        check("s6_open", {31'd0, entry_gate_open}, 1);
        entry_pass = 1'b1;
        tick(1);
        entry_pass = 1'b0;
        push(1'b0, 1'b0, cyc + 1);
        tick(6);
        check("s6_closed", {31'd0, entry_gate_open}, 0);
        entry_req = 1'b0;
        tick(3);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
